// File: rtl/armleocpu_jtag_dtm.sv
//==============================================================================
// armleocpu_jtag_dtm : RISC-V JTAG DTM (IDCODE/DTMCS/DMI/BYPASS DRs, DMI master)
// Optional IDCODE register enabled by ARMLEOCPU_JTAG_DTM_IDCODE_EN. Revision 1.0
//==============================================================================
`default_nettype none

module armleocpu_jtag_dtm #(
    parameter int          IR_LENGTH    = 5,
    parameter int          ABITS        = 7,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tck_rise_i,
    input  logic [IR_LENGTH-1:0] ir_i,
    input  logic                 capture_dr_i,
    input  logic                 shift_dr_i,
    input  logic                 update_dr_i,
    input  logic                 td_i,
    output logic                 tdo_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [ABITS-1:0]     dmi_req_addr_o,
    output logic [31:0]          dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic                 dmi_resp_err_i
);

    localparam int         W_DMI       = ABITS + 34;
    localparam logic [5:0] ABITS6      = 6'(ABITS);
    localparam logic [1:0] SEL_BYPASS  = 2'd0;
    localparam logic [1:0] SEL_IDCODE  = 2'd1;
    localparam logic [1:0] SEL_DTMCS   = 2'd2;
    localparam logic [1:0] SEL_DMI     = 2'd3;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_WRITE    = 2'd2;
    localparam logic [1:0] STAT_FAILED = 2'd2;
    localparam logic [1:0] STAT_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [4:0]       ir5;
    logic [1:0]       sel;
    logic [31:0]      dtmcs_val;
    state_t           state_q, state_d;
    logic [W_DMI-1:0] sr_q, sr_d;
    logic [1:0]       sticky_q, sticky_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      last_data_q, last_data_d;
    logic             drain_q, drain_d;
    logic             req_valid_q, resp_ready_q;

    if (IR_LENGTH >= 5) begin : g_ir_trunc
        assign ir5 = ir_i[4:0];
    end else begin : g_ir_pad
        assign ir5 = {{(5 - IR_LENGTH){1'b0}}, ir_i};
    end

    always_comb begin
        sel = SEL_BYPASS;
        case (ir5)
`ifdef ARMLEOCPU_JTAG_DTM_IDCODE_EN
            5'h01:   sel = SEL_IDCODE;
`endif
            5'h10:   sel = SEL_DTMCS;
            5'h11:   sel = SEL_DMI;
            default: sel = SEL_BYPASS;
        endcase
    end

    assign dtmcs_val = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, sticky_q, ABITS6, 4'd1};

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        sticky_d    = sticky_q;
        addr_d      = addr_q;
        data_d      = data_q;
        op_d        = op_q;
        last_data_d = last_data_q;
        drain_d     = drain_q;

        // DM side is resolved first so a same-cycle Update sees the post-response state.
        if (drain_q && dmi_resp_valid_i) begin
            drain_d = 1'b0;
        end
        case (state_q)
            ST_REQ: begin
                if (dmi_req_ready_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (dmi_resp_valid_i && !drain_q) begin
                    state_d = ST_IDLE;
                    if (op_q == OP_READ) begin
                        last_data_d = dmi_resp_data_i;
                    end
                    if (dmi_resp_err_i && (sticky_q == 2'd0)) begin
                        sticky_d = STAT_FAILED;
                    end
                end
            end
            default: ;
        endcase

        if (tck_rise_i) begin
            if (capture_dr_i) begin
                case (sel)
                    SEL_IDCODE: sr_d = {{(W_DMI - 32){1'b0}}, IDCODE_VALUE};
                    SEL_DTMCS:  sr_d = {{(W_DMI - 32){1'b0}}, dtmcs_val};
                    SEL_DMI: begin
                        if (state_q != ST_IDLE) begin
                            sr_d     = {addr_q, last_data_q, STAT_BUSY};
                            sticky_d = STAT_BUSY;
                        end else begin
                            sr_d = {addr_q, last_data_q, sticky_q};
                        end
                    end
                    default:    sr_d = '0;
                endcase
            end else if (shift_dr_i) begin
                case (sel)
                    SEL_IDCODE, SEL_DTMCS: sr_d = {{(W_DMI - 32){1'b0}}, td_i, sr_q[31:1]};
                    SEL_DMI:               sr_d = {td_i, sr_q[W_DMI-1:1]};
                    default:               sr_d = {{(W_DMI - 1){1'b0}}, td_i};
                endcase
            end else if (update_dr_i) begin
                if (sel == SEL_DTMCS) begin
                    if (sr_q[17]) begin
                        // An already-accepted request still owes a response; swallow it.
                        sticky_d = 2'd0;
                        if (state_d == ST_RESP) begin
                            drain_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else if (sr_q[16]) begin
                        sticky_d = 2'd0;
                    end
                end else if ((sel == SEL_DMI) && (sticky_d == 2'd0) &&
                             ((sr_q[1:0] == OP_READ) || (sr_q[1:0] == OP_WRITE))) begin
                    if (state_d != ST_IDLE) begin
                        sticky_d = STAT_BUSY;
                    end else begin
                        state_d = ST_REQ;
                        addr_d  = sr_q[W_DMI-1:34];
                        data_d  = sr_q[33:2];
                        op_d    = sr_q[1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            sticky_q     <= 2'd0;
            addr_q       <= '0;
            data_q       <= 32'd0;
            op_q         <= 2'd0;
            last_data_q  <= 32'd0;
            drain_q      <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            sticky_q     <= sticky_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            op_q         <= op_d;
            last_data_q  <= last_data_d;
            drain_q      <= drain_d;
            req_valid_q  <= (state_d == ST_REQ);
            resp_ready_q <= (state_d == ST_RESP) || drain_d;
        end
    end

    assign tdo_o            = sr_q[0];
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_req_op_o     = op_q;
    assign dmi_resp_ready_o = resp_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_armleocpu_jtag_dtm.sv
//==============================================================================
// tb_armleocpu_jtag_dtm : directed bench with a DM responder and request queue.
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_armleocpu_jtag_dtm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tck_rise_i = 1'b0;
    logic [4:0]  ir_i = 5'h1F;
    logic        capture_dr_i = 1'b0;
    logic        shift_dr_i = 1'b0;
    logic        update_dr_i = 1'b0;
    logic        td_i = 1'b0;
    logic        tdo_o;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i = 1'b0;
    logic [6:0]  dmi_req_addr_o;
    logic [31:0] dmi_req_data_o;
    logic [1:0]  dmi_req_op_o;
    logic        dmi_resp_valid_i = 1'b0;
    logic        dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i = 32'd0;
    logic        dmi_resp_err_i = 1'b0;

    armleocpu_jtag_dtm dut (
        .clk              (clk),
        .rst              (rst),
        .tck_rise_i       (tck_rise_i),
        .ir_i             (ir_i),
        .capture_dr_i     (capture_dr_i),
        .shift_dr_i       (shift_dr_i),
        .update_dr_i      (update_dr_i),
        .td_i             (td_i),
        .tdo_o            (tdo_o),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_err_i   (dmi_resp_err_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } req_t;

    req_t        exp_q[$];
    req_t        r_pop;
    int          checks = 0;
    int          errors = 0;
    int          ready_delay = 0;
    int          resp_delay = 0;
    bit          stall = 1'b0;
    logic [31:0] resp_data_v = 32'd0;
    logic        resp_err_v = 1'b0;
    bit          pending = 1'b0;
    int          rdy_cnt = 0;
    int          rsp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    // DM responder: pops the expected request on handshake and answers after a delay.
    always @(negedge clk) begin
        dmi_req_ready_i  = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_err_i   = 1'b0;
        dmi_resp_data_i  = 32'd0;
        if (rst) begin
            pending = 1'b0;
            rdy_cnt = 0;
            rsp_cnt = 0;
        end else if (pending) begin
            if (dmi_resp_ready_o && !stall) begin
                if (rsp_cnt >= resp_delay) begin
                    dmi_resp_valid_i = 1'b1;
                    dmi_resp_data_i  = resp_data_v;
                    dmi_resp_err_i   = resp_err_v;
                    pending          = 1'b0;
                end else begin
                    rsp_cnt++;
                end
            end
        end else if (dmi_req_valid_o) begin
            if (rdy_cnt >= ready_delay) begin
                dmi_req_ready_i = 1'b1;
                pending         = 1'b1;
                rdy_cnt         = 0;
                rsp_cnt         = 0;
                if (exp_q.size() > 0) begin
                    r_pop = exp_q.pop_front();
                    check("req_addr", 64'(dmi_req_addr_o), 64'(r_pop.addr));
                    check("req_data", 64'(dmi_req_data_o), 64'(r_pop.data));
                    check("req_op", 64'(dmi_req_op_o), 64'(r_pop.op));
                end else begin
                    check("req_unexpected", 64'(exp_q.size()), 64'd1);
                end
            end else begin
                rdy_cnt++;
            end
        end else begin
            rdy_cnt = 0;
        end
    end

    task automatic tick(input bit cap, input bit sh, input bit upd, input logic td);
        capture_dr_i = cap;
        shift_dr_i   = sh;
        update_dr_i  = upd;
        td_i         = td;
        tck_rise_i   = 1'b1;
        @(negedge clk);
        tck_rise_i   = 1'b0;
        capture_dr_i = 1'b0;
        shift_dr_i   = 1'b0;
        update_dr_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic scan_dr(input int w, input logic [63:0] din, input bit upd,
                           output logic [63:0] dout);
        dout = 64'd0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < w; i++) begin
            dout[i] = tdo_o;
            tick(1'b0, 1'b1, 1'b0, din[i]);
        end
        if (upd) tick(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                            input bit upd, input bit push, output logic [63:0] dout);
        req_t r;
        r.addr = a;
        r.data = d;
        r.op   = op;
        if (push) exp_q.push_back(r);
        ir_i = 5'h11;
        scan_dr(41, dmi_word(a, d, op), upd, dout);
    endtask

    task automatic dtmcs_scan(input logic [31:0] din, output logic [63:0] dout);
        ir_i = 5'h10;
        scan_dr(32, {32'b0, din}, 1'b1, dout);
    endtask

    task automatic wait_done(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !pending && !dmi_req_valid_o && !dmi_resp_ready_o;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_pending(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = pending;
        end
        check(tag, 64'(got), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] dout;
        logic [31:0] pat;
        bit          seen;

        @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst_tdo", 64'(tdo_o), 64'd0);
        check("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
        check("rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        check("rst_addr", 64'(dmi_req_addr_o), 64'd0);
        check("rst_data", 64'(dmi_req_data_o), 64'd0);
        check("rst_op", 64'(dmi_req_op_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        pat  = 32'hA5C3_0F96;
        ir_i = 5'h01;
        scan_dr(32, {32'b0, pat}, 1'b0, dout);
`ifdef ARMLEOCPU_JTAG_DTM_IDCODE_EN
        check("idcode", dout, 64'h0000_0001);
`else
        check("idcode_as_bypass", dout, {32'b0, pat[30:0], 1'b0});
`endif
        ir_i = 5'h1F;
        scan_dr(8, 64'hFF, 1'b0, dout);
        check("bypass", dout, 64'hFE);

        dtmcs_scan(32'd0, dout);
        check("dtmcs_reset", dout, 64'h1071);

        // Write with a ready delay of 3 and a clean response.
        ready_delay = 3;
        resp_delay  = 0;
        dmi_scan(7'h10, 32'hDEADBEEF, 2'd2, 1'b1, 1'b1, dout);
        check("dmi_cap_initial", dout, dmi_word(7'h00, 32'h0, 2'd0));
        check("wr_valid_rise", 64'(dmi_req_valid_o), 64'd1);
        check("wr_addr_out", 64'(dmi_req_addr_o), 64'h10);
        check("wr_data_out", 64'(dmi_req_data_o), 64'hDEADBEEF);
        check("wr_op_out", 64'(dmi_req_op_o), 64'd2);
        wait_done("wr_done");
        dmi_scan(7'h00, 32'h0, 2'd0, 1'b1, 1'b0, dout);
        check("wr_status_ok", dout, dmi_word(7'h10, 32'h0, 2'd0));

        // Minimum round trip read.
        ready_delay = 0;
        resp_data_v = 32'h1234_5678;
        dmi_scan(7'h05, 32'h0, 2'd1, 1'b1, 1'b1, dout);
        check("rt_resp_ready", 64'(dmi_resp_ready_o), 64'd1);
        check("rt_req_dropped", 64'(dmi_req_valid_o), 64'd0);
        @(negedge clk);
        check("rt_idle", 64'(dmi_resp_ready_o), 64'd0);
        dmi_scan(7'h00, 32'h0, 2'd0, 1'b0, 1'b0, dout);
        check("rd_capture", dout, dmi_word(7'h05, 32'h1234_5678, 2'd0));

        // Stalled response then a second read -> busy.
        stall = 1'b1;
        dmi_scan(7'h04, 32'h0, 2'd1, 1'b1, 1'b1, dout);
        wait_pending("stall_accept");
        dmi_scan(7'h04, 32'h0, 2'd1, 1'b1, 1'b0, dout);
        check("busy_capture", dout, dmi_word(7'h04, 32'h1234_5678, 2'd3));
        check("busy_no_req", 64'(dmi_req_valid_o), 64'd0);
        resp_data_v = 32'hCAFE_F00D;
        stall = 1'b0;
        wait_done("stall_done");
        dmi_scan(7'h00, 32'h0, 2'd0, 1'b0, 1'b0, dout);
        check("busy_sticky", dout, dmi_word(7'h04, 32'hCAFE_F00D, 2'd3));
        dtmcs_scan(32'h0001_0000, dout);
        check("dtmcs_busy", dout, 64'h1C71);
        dmi_scan(7'h00, 32'h0, 2'd0, 1'b0, 1'b0, dout);
        check("dmireset_clears", dout, dmi_word(7'h04, 32'hCAFE_F00D, 2'd0));

        // Error response -> failed sticky blocks further requests.
        resp_err_v  = 1'b1;
        resp_data_v = 32'h1111_1111;
        dmi_scan(7'h08, 32'h0, 2'd1, 1'b1, 1'b1, dout);
        wait_done("err_done");
        resp_err_v = 1'b0;
        dmi_scan(7'h00, 32'h0, 2'd0, 1'b0, 1'b0, dout);
        check("err_capture", dout, dmi_word(7'h08, 32'h1111_1111, 2'd2));
        dmi_scan(7'h08, 32'h55, 2'd2, 1'b1, 1'b0, dout);
        check("err_capture2", dout, dmi_word(7'h08, 32'h1111_1111, 2'd2));
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | dmi_req_valid_o | dmi_resp_ready_o;
        end
        check("err_blocks_req", 64'(seen), 64'd0);
        dtmcs_scan(32'h0001_0000, dout);
        check("dtmcs_failed", dout, 64'h1871);
        dmi_scan(7'h09, 32'hA5A5_A5A5, 2'd2, 1'b1, 1'b1, dout);
        wait_done("after_reset_done");
        dmi_scan(7'h00, 32'h0, 2'd0, 1'b0, 1'b0, dout);
        check("after_reset_capture", dout, dmi_word(7'h09, 32'h1111_1111, 2'd0));

        // dmihardreset while the request is waiting for ready.
        ready_delay = 1000;
        dmi_scan(7'h0A, 32'h0F0F_0F0F, 2'd2, 1'b1, 1'b1, dout);
        check("hr_valid_up", 64'(dmi_req_valid_o), 64'd1);
        dtmcs_scan(32'h0002_0000, dout);
        check("hr_dtmcs_cap", dout, 64'h1071);
        check("hr_valid_drop", 64'(dmi_req_valid_o), 64'd0);
        check("hr_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        exp_q.delete();
        ready_delay = 0;
        repeat (3) @(negedge clk);
        check("hr_stays_idle", 64'(dmi_req_valid_o), 64'd0);
        dmi_scan(7'h00, 32'h0, 2'd0, 1'b0, 1'b0, dout);
        check("hr_capture", dout, dmi_word(7'h0A, 32'h1111_1111, 2'd0));

        // rst while waiting for a response.
        stall = 1'b1;
        dmi_scan(7'h0B, 32'h0000_0012, 2'd2, 1'b1, 1'b1, dout);
        wait_pending("rst_accept");
        repeat (3) @(negedge clk);
        check("resp_wait", 64'(dmi_resp_ready_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tdo", 64'(tdo_o), 64'd0);
        check("mid_rst_valid", 64'(dmi_req_valid_o), 64'd0);
        check("mid_rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        check("mid_rst_addr", 64'(dmi_req_addr_o), 64'd0);
        check("mid_rst_data", 64'(dmi_req_data_o), 64'd0);
        check("mid_rst_op", 64'(dmi_req_op_o), 64'd0);
        rst   = 1'b0;
        stall = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_resp_ready", 64'(dmi_resp_ready_o), 64'd0);
        dmi_scan(7'h00, 32'h0, 2'd0, 1'b0, 1'b0, dout);
        check("post_rst_capture", dout, dmi_word(7'h00, 32'h0, 2'd0));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
